// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder: one request channel carrying
// the immediate, format select and base word, and one result channel.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_immsel;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, in_immsel, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_immsel, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: scatters an immediate into the selected instruction
// format's bit fields of a base word and flags immediates the format cannot hold.
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  imm_encoder_if.slave     bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0] imm;
  logic [31:0] fld;
  logic [31:0] mask;
  logic        err;
  logic        sext_11;
  logic        sext_12;
  logic        sext_20;

  logic        s1_valid_q;
  logic [31:0] s1_base_q;
  logic [31:0] s1_fld_q;
  logic [31:0] s1_mask_q;
  logic        s1_err_q;

  logic        s2_valid_q;
  logic [31:0] s2_inst_q;
  logic        s2_err_q;

  logic        s1_free;
  logic        s2_free;
  logic        out_hs;

  assign imm = bus.in_imm;

  // True when the upper bits are a pure sign extension of the field's top bit.
  assign sext_11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext_12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext_20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    fld  = '0;
    mask = '0;
    err  = 1'b0;
    case (bus.in_immsel)
      3'b000: begin
        mask       = 32'hFFF0_0000;
        fld[31:20] = imm[11:0];
        err        = ~sext_11;
      end
      3'b001: begin
        mask       = 32'hFE00_0F80;
        fld[31:25] = imm[11:5];
        fld[11:7]  = imm[4:0];
        err        = ~sext_11;
      end
      3'b010: begin
        mask       = 32'hFE00_0F80;
        fld[31]    = imm[12];
        fld[7]     = imm[11];
        fld[30:25] = imm[10:5];
        fld[11:8]  = imm[4:1];
        err        = imm[0] | ~sext_12;
      end
      3'b011: begin
        mask       = 32'hFFFF_F000;
        fld[31:12] = imm[31:12];
        err        = |imm[11:0];
      end
      3'b100: begin
        mask       = 32'hFFFF_F000;
        fld[31]    = imm[20];
        fld[19:12] = imm[19:12];
        fld[20]    = imm[11];
        fld[30:21] = imm[10:1];
        err        = imm[0] | ~sext_20;
      end
      3'b101: begin
        mask       = 32'h000F_8000;
        fld[19:15] = imm[4:0];
        err        = |imm[31:5];
      end
      default: err = 1'b1;
    endcase
  end

  // A stage may load when empty or when its current contents move on this cycle.
  assign s2_free      = ~s2_valid_q | bus.out_ready;
  assign s1_free      = ~s1_valid_q | s2_free;
  assign out_hs       = s2_valid_q & bus.out_ready;
  assign bus.in_ready = s1_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_base_q  <= '0;
      s1_fld_q   <= '0;
      s1_mask_q  <= '0;
      s1_err_q   <= 1'b0;
    end else if (s1_free) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_base_q <= bus.in_base;
        s1_fld_q  <= fld;
        s1_mask_q <= mask;
        s1_err_q  <= err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_free) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_q <= (s1_base_q & ~s1_mask_q) | s1_fld_q;
        s2_err_q  <= s1_err_q;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_inst  = s2_inst_q;
  assign bus.out_err   = s2_err_q;

  // Clear takes priority over a coincident handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (cnt_clr) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_hs) begin
      enc_count <= enc_count + 1'b1;
      if (s2_err_q) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed cases with literal expectations plus randomized traffic
// checked every cycle against a bit-mapping reference model and a round-trip decoder.
module tb_imm_encoder;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Which immediate bit lands on instruction bit b for format fmt (-1: base bit kept).
  function automatic int src_bit(input int fmt, input int b);
    int r;
    r = -1;
    case (fmt)
      0: if (b >= 20) r = b - 20;
      1: if (b >= 25) r = b - 20; else if (b >= 7 && b <= 11) r = b - 7;
      2: if (b == 31) r = 12; else if (b == 7) r = 11;
         else if (b >= 25 && b <= 30) r = b - 20; else if (b >= 8 && b <= 11) r = b - 7;
      3: if (b >= 12) r = b;
      4: if (b == 31) r = 20; else if (b == 20) r = 11;
         else if (b >= 12 && b <= 19) r = b; else if (b >= 21 && b <= 30) r = b - 20;
      5: if (b >= 15 && b <= 19) r = b - 15;
      default: r = -1;
    endcase
    return r;
  endfunction

  function automatic void model(input logic [2:0] sel, input logic [31:0] imm,
                                input logic [31:0] base, output logic [31:0] inst,
                                output logic err);
    longint s;
    int     src;
    s    = longint'($signed(imm));
    inst = base;
    for (int b = 0; b < 32; b++) begin
      src = src_bit(int'(sel), b);
      if (src >= 0) inst[b] = imm[src];
    end
    case (sel)
      3'd0, 3'd1: err = !(s >= -2048 && s <= 2047);
      3'd2:       err = imm[0] || !(s >= -4096 && s <= 4095);
      3'd3:       err = (imm % 32'd4096) != 0;
      3'd4:       err = imm[0] || !(s >= -(64'sd1 << 20) && s < (64'sd1 << 20));
      3'd5:       err = imm > 32'd31;
      default:    err = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] sel);
    logic [31:0] r;
    case (sel)
      3'd0:    r = {{20{i[31]}}, i[31:20]};
      3'd1:    r = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    r = {i[31:12], 12'b0};
      3'd4:    r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = {27'b0, i[19:15]};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_imm(input logic [2:0] sel);
    logic [31:0] r;
    case (sel)
      3'd0, 3'd1: r = 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd2:       r = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      3'd3:       r = $urandom & 32'hFFFF_F000;
      3'd4:       r = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
      default:    r = 32'($urandom_range(0, 31));
    endcase
    return r;
  endfunction

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t             q[$];
  logic [CNT_W-1:0] m_enc = '0;
  logic [CNT_W-1:0] m_err = '0;

  // Compare process: every cycle the outputs are meaningful, check against the model.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] inst;
    logic        err;
    if (rst) begin
      q.delete();
      m_enc = '0;
      m_err = '0;
    end else begin
      chk("enc_count", 32'(enc_count), 32'(m_enc));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk1("spurious out_valid", bus.out_valid, 1'b0);
        end else begin
          e = q[0];
          chk("out_inst", bus.out_inst, e.inst);
          chk1("out_err", bus.out_err, e.err);
          if (!e.err) chk("round-trip imm", decode(bus.out_inst, e.sel), e.imm);
        end
      end
      if (cnt_clr) begin
        m_enc = '0;
        m_err = '0;
      end else if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        m_enc = m_enc + 1'b1;
        if (q[0].err) m_err = m_err + 1'b1;
      end
      if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        model(bus.in_immsel, bus.in_imm, bus.in_base, inst, err);
        e.sel  = bus.in_immsel;
        e.imm  = bus.in_imm;
        e.inst = inst;
        e.err  = err;
        q.push_back(e);
      end
    end
  end

  logic [31:0] c_inst[$];
  logic        c_err[$];
  int          c_cyc[$];

  task automatic collect(input int n);
    c_inst.delete();
    c_err.delete();
    c_cyc.delete();
    for (int k = 0; k < 40 && c_inst.size() < n; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        c_inst.push_back(bus.out_inst);
        c_err.push_back(bus.out_err);
        c_cyc.push_back(k);
      end
    end
    chk("collected results", 32'(c_inst.size()), 32'(n));
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    bus.in_valid  = 1'b1;
    bus.in_immsel = sel;
    bus.in_imm    = imm;
    bus.in_base   = base;
  endtask

  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    drive(sel, imm, base);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk1("send accepted within bound", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  logic [2:0]  bp_sel[3]  = '{3'd0, 3'd1, 3'd3};
  logic [31:0] bp_imm[3]  = '{32'h0000_0005, 32'hFFFF_FFFF, 32'hABCD_E000};
  logic [31:0] bp_base[3] = '{32'h0000_0013, 32'h0000_0023, 32'h0000_00B7};
  logic [31:0] bp_exp[3]  = '{32'h0050_0013, 32'hFE00_0FA3, 32'hABCD_E0B7};

  initial begin
    logic [31:0] mi;
    logic        me;
    logic        acc;
    int          accepted;
    int          idx;
    int          sent;
    int          seen;
    logic [2:0]  sel;

    bus.in_valid  = 1'b0;
    bus.in_immsel = '0;
    bus.in_imm    = '0;
    bus.in_base   = '0;
    bus.out_ready = 1'b0;

    // Literal pins of the reference model.
    model(3'd0, 32'hFFFF_F800, 32'h13, mi, me);
    chk("model I literal", mi, 32'h8000_0013);
    model(3'd2, 32'h10, 32'h63, mi, me);
    chk("model B literal", mi, 32'h0000_0863);
    model(3'd3, 32'h1234_5001, 32'h37, mi, me);
    chk1("model U err literal", me, 1'b1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("reset out_valid", bus.out_valid, 1'b0);
    chk("reset out_inst", bus.out_inst, 32'h0);
    chk1("reset out_err", bus.out_err, 1'b0);
    chk("reset enc_count", 32'(enc_count), 32'h0);
    chk("reset err_count", 32'(err_count), 32'h0);
    chk1("reset in_ready", bus.in_ready, 1'b1);

    // Single I-type
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    fork
      send(3'd0, 32'hFFFF_F800, 32'h13);
      collect(1);
    join
    chk("single I inst", c_inst[0], 32'h8000_0013);
    chk1("single I err", c_err[0], 1'b0);
    chk("single I latency", 32'(c_cyc[0]), 32'd2);
    @(negedge clk);
    chk("single I enc_count", 32'(enc_count), 32'd1);

    // Back-to-back formats
    @(posedge clk);
    #1;
    fork
      begin
        send(3'd2, 32'h10, 32'h63);
        send(3'd4, 32'h800, 32'h6F);
        send(3'd5, 32'h1F, 32'h73);
      end
      collect(3);
    join
    chk("b2b B", c_inst[0], 32'h0000_0863);
    chk("b2b J", c_inst[1], 32'h0010_006F);
    chk("b2b CSR", c_inst[2], 32'h000F_8073);
    chk("b2b gap 1", 32'(c_cyc[1] - c_cyc[0]), 32'd1);
    chk("b2b gap 2", 32'(c_cyc[2] - c_cyc[1]), 32'd1);

    // Error cases
    @(posedge clk);
    #1;
    fork
      begin
        send(3'd0, 32'h800, 32'h13);
        send(3'd3, 32'h1234_5001, 32'h37);
        send(3'd7, 32'h5555_5555, 32'hDEAD_BEEF);
      end
      collect(3);
    join
    chk("err I inst", c_inst[0], 32'h8000_0013);
    chk1("err I flag", c_err[0], 1'b1);
    chk("err U inst", c_inst[1], 32'h1234_5037);
    chk1("err U flag", c_err[1], 1'b1);
    chk("err illegal inst", c_inst[2], 32'hDEAD_BEEF);
    chk1("err illegal flag", c_err[2], 1'b1);
    @(negedge clk);
    chk("err_count after errors", 32'(err_count), 32'd3);
    chk("enc_count after errors", 32'(enc_count), 32'd7);

    // Backpressure: two buffered at most
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    idx = 0;
    accepted = 0;
    drive(bp_sel[0], bp_imm[0], bp_base[0]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted++;
        if (idx < 2) idx++;
        drive(bp_sel[idx], bp_imm[idx], bp_base[idx]);
      end
    end
    @(negedge clk);
    chk("bp accepted", 32'(accepted), 32'd2);
    chk1("bp in_ready low", bus.in_ready, 1'b0);
    chk1("bp out_valid", bus.out_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("bp stable inst", bus.out_inst, bp_exp[0]);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 20 && bus.in_valid; k++) begin
          @(negedge clk);
          acc = bus.in_ready;
          @(posedge clk);
          #1;
          if (acc) bus.in_valid = 1'b0;
        end
      end
      collect(3);
    join
    for (int k = 0; k < 3; k++) chk("bp drain order", c_inst[k], bp_exp[k]);

    // Reset with both stages full
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(3'd0, 32'h1, 32'h13);
    send(3'd0, 32'h2, 32'h13);
    @(negedge clk);
    chk1("pre-reset full", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async reset out_valid", bus.out_valid, 1'b0);
    chk("async reset out_inst", bus.out_inst, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("no stale output", 32'(seen), 32'd0);
    chk("post-reset enc_count", 32'(enc_count), 32'd0);
    chk("post-reset err_count", 32'(err_count), 32'd0);

    // Randomized traffic with random backpressure and occasional clears
    @(posedge clk);
    #1;
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 63) == 0);
      if (!bus.in_valid || acc) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 9) == 0) begin
            drive(3'($urandom_range(0, 7)), $urandom, $urandom);
          end else begin
            sel = 3'($urandom_range(0, 5));
            drive(sel, rand_imm(sel), $urandom);
          end
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("random requests accepted", 32'(sent), 32'd1000);
    bus.in_valid  = 1'b0;
    cnt_clr       = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("random drain", 32'(q.size()), 32'd0);

    // Clear coincident with a handshake
    @(posedge clk);
    #1;
    send(3'd6, 32'h0, 32'h13);
    @(posedge clk);
    #1;
    chk1("clr cycle has result", bus.out_valid, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr wins enc_count", 32'(enc_count), 32'd0);
    chk("clr wins err_count", 32'(err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
